// File: rtl/led_seq_pkg.sv
// Shared constants and types for the LED pattern sequencer.
package led_seq_pkg;

    // Pattern step modes as presented on the mode input.
    localparam logic [1:0] MODE_ROL    = 2'd0;
    localparam logic [1:0] MODE_ROR    = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_COUNT  = 2'd3;

    // Sequencer control states.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // The LED PIO exposes a single data register at address 0.
    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;
    localparam int         PIO_DATA_W    = 32;

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Write-only bus towards the green-LED PIO slave.
//
// Transfer semantics: the slave has no waitrequest, so a write is complete in
// exactly one cycle. A write happens in every cycle where pio_chipselect=1 and
// pio_write_n=0 (always together, address 0). In all other cycles
// pio_chipselect=0 and pio_write_n=1 and pio_writedata holds its last value.
interface led_pattern_sequencer_if;
    import led_seq_pkg::*;

    logic [1:0]            pio_address;
    logic                  pio_chipselect;
    logic                  pio_write_n;
    logic [PIO_DATA_W-1:0] pio_writedata;

    modport master (
        output pio_address,
        output pio_chipselect,
        output pio_write_n,
        output pio_writedata
    );

    modport slave (
        input pio_address,
        input pio_chipselect,
        input pio_write_n,
        input pio_writedata
    );

endinterface

// File: rtl/led_tick_prescaler.sv
// Free-running step prescaler: counts 0..TICK_DIV-1 while enabled and flags
// the terminal count. clr forces the count back to zero.
module led_tick_prescaler #(
    parameter int TICK_DIV = 6250000,
    parameter int DIV_W    = 23
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [DIV_W-1:0] TERM = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] count_d;

    // Next count: clear has priority, otherwise wrap at the terminal count.
    always_comb begin
        tick    = en && (count_q == TERM);
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = tick ? '0 : count_q + DIV_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: steps a pattern at a fixed tick rate and shares the
// LED PIO write port with a host pass-through channel (host has priority).
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 6250000,
    parameter int DIV_W    = 23
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic [1:0]               mode,
    input  logic [WIDTH-1:0]         seed,
    input  logic                     host_wr,
    input  logic [WIDTH-1:0]         host_data,
    led_pattern_sequencer_if.master  pio,
    output logic [WIDTH-1:0]         pattern,
    output logic                     busy,
    output logic [0:0]               state_dbg
);

    localparam logic [0:0] S_IDLE = ST_IDLE;
    localparam logic [0:0] S_RUN  = ST_RUN;

    logic [0:0]            state_q, state_d;
    logic [WIDTH-1:0]      pattern_q, pattern_d;
    logic                  dir_left_q, dir_left_d;
    logic                  pending_q, pending_d;
    logic                  cs_q, cs_d;
    logic                  write_n_q, write_n_d;
    logic [PIO_DATA_W-1:0] wdata_q, wdata_d;

    logic                  run;
    logic                  tick;
    logic                  load;
    logic                  advance;
    logic                  host_sel;
    logic                  seq_sel;
    logic [WIDTH-1:0]      step_pat;
    logic                  step_dir_left;

    assign run = (state_q == S_RUN);

    // Prescaler only runs in RUN; any start/stop restarts it from zero.
    led_tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .DIV_W    (DIV_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (start || stop || !run),
        .en    (run),
        .tick  (tick)
    );

    // Next pattern for one step in the currently selected mode.
    always_comb begin
        step_pat      = pattern_q;
        step_dir_left = dir_left_q;
        case (mode)
            MODE_ROL:   step_pat = {pattern_q[WIDTH-2:0], pattern_q[WIDTH-1]};
            MODE_ROR:   step_pat = {pattern_q[0], pattern_q[WIDTH-1:1]};
            MODE_COUNT: step_pat = pattern_q + WIDTH'(1);
            MODE_BOUNCE: begin
                // Reverse at the edge bit; an all-zero pattern just stays zero.
                if (dir_left_q) begin
                    if (pattern_q[WIDTH-1]) begin
                        step_dir_left = 1'b0;
                        step_pat      = pattern_q >> 1;
                    end else begin
                        step_pat      = pattern_q << 1;
                    end
                end else begin
                    if (pattern_q[0]) begin
                        step_dir_left = 1'b1;
                        step_pat      = pattern_q << 1;
                    end else begin
                        step_pat      = pattern_q >> 1;
                    end
                end
            end
            default: step_pat = pattern_q;
        endcase
    end

    // Control FSM, pattern update and write-port arbitration.
    always_comb begin
        state_d    = state_q;
        pattern_d  = pattern_q;
        dir_left_d = dir_left_q;
        pending_d  = pending_q;
        wdata_d    = wdata_q;

        // stop overrides start in the same cycle.
        load    = start && !stop;
        advance = run && tick && !start && !stop;

        if (stop) begin
            state_d = S_IDLE;
        end else if (start) begin
            state_d = S_RUN;
        end

        if (load) begin
            pattern_d  = seed;
            dir_left_d = 1'b1;
        end else if (advance) begin
            pattern_d  = step_pat;
            dir_left_d = step_dir_left;
        end

        // Host always wins; a deferred pattern write goes out later with
        // whatever the pattern is by then.
        host_sel = host_wr;
        seq_sel  = !host_wr && pending_q && !stop;

        if (seq_sel) begin
            pending_d = 1'b0;
        end
        if (load || advance) begin
            pending_d = 1'b1;
        end
        if (stop) begin
            pending_d = 1'b0;
        end

        cs_d      = host_sel || seq_sel;
        write_n_d = !cs_d;
        if (host_sel) begin
            wdata_d = PIO_DATA_W'(host_data);
        end else if (seq_sel) begin
            wdata_d = PIO_DATA_W'(pattern_q);
        end
    end

    // State and registered PIO outputs; reset drops any strobe in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pattern_q  <= '0;
            dir_left_q <= 1'b1;
            pending_q  <= 1'b0;
            cs_q       <= 1'b0;
            write_n_q  <= 1'b1;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            pattern_q  <= pattern_d;
            dir_left_q <= dir_left_d;
            pending_q  <= pending_d;
            cs_q       <= cs_d;
            write_n_q  <= write_n_d;
            wdata_q    <= wdata_d;
        end
    end

    assign pio.pio_address    = PIO_DATA_ADDR;
    assign pio.pio_chipselect = cs_q;
    assign pio.pio_write_n    = write_n_q;
    assign pio.pio_writedata  = wdata_q;

    assign pattern   = pattern_q;
    assign busy      = run;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer with a short tick period.
module tb_led_pattern_sequencer;

    localparam int W  = 8;
    localparam int TD = 4;

    // Clock / reset and DUT hookup
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [1:0]   mode = 2'd0;
    logic [W-1:0] seed = '0;
    logic         host_wr = 1'b0;
    logic [W-1:0] host_data = '0;
    logic [W-1:0] pattern;
    logic         busy;
    logic [0:0]   state_dbg;

    led_pattern_sequencer_if pio_if ();

    led_pattern_sequencer #(
        .WIDTH    (W),
        .TICK_DIV (TD),
        .DIV_W    (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .seed      (seed),
        .host_wr   (host_wr),
        .host_data (host_data),
        .pio       (pio_if),
        .pattern   (pattern),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: expected write data and the cycle it must appear in
    logic [31:0] exp_q[$];
    int          exp_cyc_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] mon_e;
    int          mon_ec;

    always @(negedge clk) begin
        if (pio_if.pio_chipselect === 1'b1 || pio_if.pio_write_n === 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe cyc=%0d data=%h expected none", cyc, pio_if.pio_writedata);
            end else begin
                mon_e  = exp_q.pop_front();
                mon_ec = exp_cyc_q.pop_front();
                if (pio_if.pio_chipselect !== 1'b1 || pio_if.pio_write_n !== 1'b0 ||
                    pio_if.pio_address !== 2'd0 || pio_if.pio_writedata !== mon_e || cyc != mon_ec) begin
                    failures++;
                    $display("FAIL strobe cyc=%0d cs=%b wn=%b addr=%0d data=%h expected data=%h cyc=%0d",
                             cyc, pio_if.pio_chipselect, pio_if.pio_write_n, pio_if.pio_address,
                             pio_if.pio_writedata, mon_e, mon_ec);
                end
            end
        end
    end

    // Driver tasks (all entered and left at a falling edge)
    task automatic expect_wr(input logic [W-1:0] d, input int at);
        exp_q.push_back(32'(d));
        exp_cyc_q.push_back(at);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic do_start(input logic [W-1:0] s, input logic [1:0] m);
        seed  = s;
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_%s outstanding=%0d required=0", name, exp_q.size());
            exp_q.delete();
            exp_cyc_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if (pio_if.pio_chipselect !== 1'b0 || pio_if.pio_write_n !== 1'b1 || pio_if.pio_address !== 2'd0 ||
            pio_if.pio_writedata !== 32'h0 || busy !== 1'b0 || pattern !== 8'h00 || state_dbg !== 1'b0) begin
            failures++;
            $display("FAIL %s cs=%b wn=%b addr=%0d wd=%h busy=%b pat=%h st=%b required 0/1/0/0/0/00/0",
                     name, pio_if.pio_chipselect, pio_if.pio_write_n, pio_if.pio_address,
                     pio_if.pio_writedata, busy, pattern, state_dbg);
        end
    endtask

    // Test scenarios
    task automatic test_reset();
        int bad = 0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("reset_values");
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pio_if.pio_write_n !== 1'b1 || busy !== 1'b0 || pattern !== 8'h00) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL idle_quiet bad_cycles=%0d required=0", bad);
        end
    endtask

    task automatic test_rotate_left();
        int c = cyc;
        logic [W-1:0] p = 8'h01;
        for (int k = 0; k < 9; k++) begin
            expect_wr(p, c + 2 + TD * k);
            p = {p[W-2:0], p[W-1]};
        end
        do_start(8'h01, 2'd0);
        checks++;
        if (busy !== 1'b1 || state_dbg !== 1'b1) begin
            failures++;
            $display("FAIL busy_after_start busy=%b st=%b required 1/1", busy, state_dbg);
        end
        wait_until(c + 2 + TD * 8 + 1);
        do_stop();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_after_stop busy=%b required 0", busy);
        end
        drain(10, "rotate_left");
    endtask

    task automatic test_bounce();
        int c = cyc;
        logic [W-1:0] tbl[10] = '{8'h40, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        for (int k = 0; k < 10; k++) expect_wr(tbl[k], c + 2 + TD * k);
        do_start(8'h40, 2'd2);
        wait_until(c + 2 + TD * 9 + 1);
        do_stop();
        drain(10, "bounce");
    endtask

    task automatic test_count_wrap();
        int c = cyc;
        logic [W-1:0] p = 8'hFE;
        for (int k = 0; k < 4; k++) begin
            expect_wr(p, c + 2 + TD * k);
            p = p + 8'd1;
        end
        do_start(8'hFE, 2'd3);
        wait_until(c + 2 + TD * 3 + 1);
        do_stop();
        drain(10, "count_wrap");
    endtask

    task automatic test_host_priority();
        int c = cyc;
        logic [W-1:0] hd;
        expect_wr(8'hA5, c + 2);
        expect_wr(8'h01, c + 3);
        expect_wr(8'h02, c + 6);
        do_start(8'h01, 2'd0);
        host_wr   = 1'b1;
        host_data = 8'hA5;
        @(negedge clk);
        host_wr = 1'b0;
        wait_until(c + 8);
        // Host holds the port across the ticks at c+9 and c+13.
        for (int i = 0; i < 5; i++) begin
            hd = W'($urandom_range(0, 255));
            expect_wr(hd, c + 9 + i);
            host_data = hd;
            host_wr   = 1'b1;
            @(negedge clk);
        end
        host_wr = 1'b0;
        expect_wr(8'h08, c + 14);
        expect_wr(8'h10, c + 18);
        wait_until(c + 19);
        do_stop();
        drain(10, "host_priority");
    endtask

    task automatic test_stop_pending();
        int c = cyc;
        do_start(8'h33, 2'd0);
        expect_wr(8'h5A, c + 2);
        stop      = 1'b1;
        host_wr   = 1'b1;
        host_data = 8'h5A;
        @(negedge clk);
        stop    = 1'b0;
        host_wr = 1'b0;
        checks++;
        if (busy !== 1'b0 || pattern !== 8'h33) begin
            failures++;
            $display("FAIL stop_pending busy=%b pat=%h required 0/33", busy, pattern);
        end
        repeat (12) @(negedge clk);
        drain(4, "stop_pending");
    endtask

    task automatic test_start_stop_same();
        seed  = 8'h77;
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        checks++;
        if (busy !== 1'b0 || state_dbg !== 1'b0) begin
            failures++;
            $display("FAIL start_stop_same busy=%b st=%b required 0/0", busy, state_dbg);
        end
        repeat (10) @(negedge clk);
        drain(4, "start_stop_same");
    endtask

    task automatic test_reset_mid_run();
        int c = cyc;
        expect_wr(8'h81, c + 2);
        do_start(8'h81, 2'd1);
        wait_until(c + 5);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("reset_mid_run");
        reset = 1'b0;
        repeat (12) @(negedge clk);
        drain(4, "reset_mid_run");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_rotate_left();
        test_bounce();
        test_count_wrap();
        test_host_priority();
        test_stop_pending();
        test_start_stop_same();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
- Controller that drives the 8-bit green-LED PIO slave, which exposes one write-only data register at address 0, 32-bit writedata, and no waitrequest.
- Steps an LED pattern at a fixed tick rate in one of four modes.
- Arbitrates the PIO write port between the sequencer and a host pass-through write channel.
- Sits between the system interconnect/host glue and the LED PIO slave port.

Parameters:
- WIDTH, 8, LED pattern width; must match the PIO out_port width.
- TICK_DIV, 6250000, clock cycles per pattern step (8 Hz at 50 MHz); minimum 2.
- DIV_W, 23, prescaler counter width; must satisfy 2^DIV_W >= TICK_DIV.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: load seed and begin stepping.
- stop  in  1  one-cycle pulse: halt stepping.
- mode  in  2  00 rotate-left, 01 rotate-right, 10 bounce, 11 binary count.
- seed  in  WIDTH  initial pattern, sampled on start.
- host_wr  in  1  host write request, single cycle.
- host_data  in  WIDTH  host LED value.
- pio_address  out  2  PIO register address; always 0.
- pio_chipselect  out  1  PIO select.
- pio_write_n  out  1  PIO write strobe, active-low.
- pio_writedata  out  32  {zeros, data}.
- pattern  out  WIDTH  current sequencer pattern.
- busy  out  1  high in RUN state.

Behaviour:
- Reset: state IDLE, pattern=0, pending=0, dir=left, prescaler=0. Outputs: pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0, busy=0.
- All pio_* outputs are registered. A write is exactly one cycle with chipselect=1, write_n=0, address=0. Otherwise chipselect=0 and write_n=1; writedata holds its last value.
- FSM states: IDLE and RUN.
  - IDLE -> RUN on start.
  - RUN -> IDLE on stop.
  - start while in RUN restarts: seed reloaded, prescaler cleared, dir=left.
  - start and stop in the same cycle: stop wins, and the state is IDLE next cycle.
- Start, start sampled in cycle n:
  - cycle n+1: pattern=seed, pending=1, prescaler=0.
  - cycle n+2: PIO strobe carrying seed, unless pre-empted by host.
- Prescaler (RUN only):
  - Counts 0..TICK_DIV-1 and wraps.
  - At terminal count, pattern advances and pending is set.
  - Steady state gives one strobe every TICK_DIV cycles: pattern updates at n+1+TICK_DIV, strobe at n+2+TICK_DIV.
  - Held at 0 in IDLE.
- Step rules:
  - rotate-left: {p[W-2:0], p[W-1]}.
  - rotate-right: {p[0], p[W-1:1]}.
  - count: p+1 modulo 2^W; 0xFF wraps to 0x00.
  - bounce: non-rotating shift in direction dir. If dir=left and p[W-1]=1, dir becomes right and p shifts right. If dir=right and p[0]=1, dir becomes left and p shifts left.
  - bounce with p=0 stays 0.
  - mode is sampled at each step, and a mid-run change takes effect at the next tick.
- Write-port arbitration, evaluated each cycle:
  - host_wr=1: issue a host write of host_data. Host has fixed priority.
  - else if pending=1: issue a write of the current pattern and clear pending.
  - Host writes are accepted in IDLE and RUN; the sequencer's pattern register is not affected.
  - A tick while pending is still set keeps pending=1. The deferred write sends the latest pattern, so intermediate steps are dropped (no queue).
- stop: pending is cleared and no further sequencer writes are issued. LEDs keep the last written value, and pattern holds.
- reset mid-operation: everything returns to reset values on the next edge, and any in-flight strobe is dropped.

Decomposition:
- Package led_seq_pkg:
  - mode encoding constants MODE_ROL=0, MODE_ROR=1, MODE_BOUNCE=2, MODE_COUNT=3.
  - state enum {ST_IDLE, ST_RUN}.
  - PIO_DATA_ADDR=0.
- Sub-module led_tick_prescaler (parameters TICK_DIV, DIV_W; ports clk, reset, clr, en, tick). It emits tick in the cycle the count equals TICK_DIV-1.

Test Plan (TICK_DIV=4):
- Reset, then idle 20 cycles -> no PIO strobe; busy=0; pio_write_n=1; pattern=0.
- start with seed=0x01, mode=00 -> strobes 0x01, 0x02, 0x04, ..., 0x80, 0x01, spaced 4 cycles apart; first strobe at n+2.
- mode=10, seed=0x40 -> write sequence 0x40, 0x80, 0x40, 0x20, ..., 0x01, 0x02. mode=11, seed=0xFE -> 0xFE, 0xFF, 0x00, 0x01.
- host_wr=1 with host_data=0xA5 in the same cycle a pattern write is due -> strobe 0xA5 that cycle, pattern write one cycle later. host_wr held for 5 cycles across a tick -> only the latest pattern is written afterwards.
- stop during RUN with pending=1 -> no further sequencer strobes, busy=0 next cycle. start and stop in the same cycle -> IDLE, no strobe.
- reset asserted mid-RUN -> all outputs at reset values the next cycle, and no strobe until a new start.
